// File: rtl/fft_ctrl_pkg.sv
// Shared types and constant helpers for the radix-4 FFT stage sequencer.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } fsm_state_e;

    // Memory read (1) plus butterfly register (1) latency between read and write-back.
    localparam int BUT_LAT = 2;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int log4(input int n);
        return log2(n) / 2;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address / twiddle generator for one (stage, butterfly) pair.
// span = N/4^(s+1) and 4^s are powers of two, so everything reduces to shifts and masks.
module fft_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int STG_W  = 4
) (
    input  logic [STG_W-1:0]  stage_i,
    input  logic [ADDR_W-3:0] b_i,
    output logic [ADDR_W-1:0] addr0_o,
    output logic [ADDR_W-1:0] addr1_o,
    output logic [ADDR_W-1:0] addr2_o,
    output logic [ADDR_W-1:0] addr3_o,
    output logic [ADDR_W-1:0] tw_o
);

    int                lspan;
    logic [ADDR_W-1:0] b_ext;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] base;

    always_comb begin
        lspan   = ADDR_W - 2 * (int'(stage_i) + 1);
        b_ext   = {2'b00, b_i};
        span    = ADDR_W'(1) << lspan;
        k       = b_ext & (span - ADDR_W'(1));
        // base = 4*g*span + k with g = b >> log2(span)
        base    = ((b_ext >> lspan) << (lspan + 2)) | k;
        addr0_o = base;
        addr1_o = base + span;
        addr2_o = base + (span << 1);
        addr3_o = base + (span << 1) + span;
        tw_o    = k << (2 * int'(stage_i));
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-4 DIF FFT: issues read addresses and
// twiddle indices each cycle, and the matching write-back addresses BUT_LAT cycles later.
module fft_stage_ctrl import fft_ctrl_pkg::*; #(
    parameter int N      = 256,
    parameter int ADDR_W = log2(N),
    parameter int STG_W  = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [STG_W-1:0]  oSTAGE,
    output logic              oRD_EN,
    output logic [ADDR_W-1:0] oRD_ADDR0,
    output logic [ADDR_W-1:0] oRD_ADDR1,
    output logic [ADDR_W-1:0] oRD_ADDR2,
    output logic [ADDR_W-1:0] oRD_ADDR3,
    output logic [ADDR_W-1:0] oTW_IDX,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR0,
    output logic [ADDR_W-1:0] oWR_ADDR1,
    output logic [ADDR_W-1:0] oWR_ADDR2,
    output logic [ADDR_W-1:0] oWR_ADDR3
);

    localparam int S  = log4(N);
    localparam int BW = ADDR_W - 2;
    localparam logic [BW-1:0]    B_LAST = BW'(N / 4 - 1);
    localparam logic [STG_W-1:0] S_LAST = STG_W'(S - 1);

    if (N < 16 || (1 << (2 * S)) != N) begin : g_bad_n
        $error("fft_stage_ctrl: N must be a power of 4 and at least 16");
    end

    fsm_state_e        state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [BW-1:0]     b_q, b_d;
    logic              fl_q, fl_d;

    logic              rd_en_d, busy_d, done_d;
    logic              rd_en_q, busy_q, done_q;
    logic [ADDR_W-1:0] gen_addr [4];
    logic [ADDR_W-1:0] gen_tw;
    logic [ADDR_W-1:0] rd_addr_q [4];
    logic [ADDR_W-1:0] tw_q;
    logic [BUT_LAT-1:0] wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q [BUT_LAT][4];

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            b_q     <= '0;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            b_q     <= b_d;
            fl_q    <= fl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        fl_d    = fl_q;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    b_d     = '0;
                end
            end
            ST_RUN: begin
                if (b_q == B_LAST) begin
                    state_d = ST_FLUSH;
                    fl_d    = 1'b0;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // Two drain cycles let the last writes of the stage land before new reads.
                if (fl_q) begin
                    if (stage_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + 1'b1;
                        b_d     = '0;
                    end
                end else begin
                    fl_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are derived from the next state so they are registered alongside the addresses.
    always_comb begin
        rd_en_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
    end

    fft_addr_gen #(
        .ADDR_W (ADDR_W),
        .STG_W  (STG_W)
    ) u_addr_gen (
        .stage_i (stage_d),
        .b_i     (b_d),
        .addr0_o (gen_addr[0]),
        .addr1_o (gen_addr[1]),
        .addr2_o (gen_addr[2]),
        .addr3_o (gen_addr[3]),
        .tw_o    (gen_tw)
    );

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tw_q    <= '0;
            wr_en_q <= '0;
            for (int i = 0; i < 4; i++) begin
                rd_addr_q[i] <= '0;
                for (int j = 0; j < BUT_LAT; j++) begin
                    wr_addr_q[j][i] <= '0;
                end
            end
        end else begin
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tw_q    <= gen_tw;
            wr_en_q <= {wr_en_q[BUT_LAT-2:0], rd_en_q};
            for (int i = 0; i < 4; i++) begin
                rd_addr_q[i]    <= gen_addr[i];
                wr_addr_q[0][i] <= rd_addr_q[i];
                for (int j = 1; j < BUT_LAT; j++) begin
                    wr_addr_q[j][i] <= wr_addr_q[j-1][i];
                end
            end
        end
    end

    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oSTAGE    = stage_q;
    assign oRD_EN    = rd_en_q;
    assign oRD_ADDR0 = rd_addr_q[0];
    assign oRD_ADDR1 = rd_addr_q[1];
    assign oRD_ADDR2 = rd_addr_q[2];
    assign oRD_ADDR3 = rd_addr_q[3];
    assign oTW_IDX   = tw_q;
    assign oWR_EN    = wr_en_q[BUT_LAT-1];
    assign oWR_ADDR0 = wr_addr_q[BUT_LAT-1][0];
    assign oWR_ADDR1 = wr_addr_q[BUT_LAT-1][1];
    assign oWR_ADDR2 = wr_addr_q[BUT_LAT-1][2];
    assign oWR_ADDR3 = wr_addr_q[BUT_LAT-1][3];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl at N=16, N=64 and N=256 (write-back scoreboard).
module tb_fft_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst16, rst_n, start16, start64, start256;

    logic       busy16, done16, rd16, wr16;
    logic [3:0] st16, tw16;
    logic [3:0] ra16 [4];
    logic [3:0] wa16 [4];

    logic       busy64, done64, rd64, wr64;
    logic [3:0] st64;
    logic [5:0] tw64;
    logic [5:0] ra64 [4];
    logic [5:0] wa64 [4];

    logic       busy256, done256, rd256, wr256;
    logic [3:0] st256;
    logic [7:0] tw256;
    logic [7:0] ra256 [4];
    logic [7:0] wa256 [4];

    logic [63:0] exp_q[$];

    fft_stage_ctrl #(.N(16)) u16 (
        .iCLK(clk), .iRESET(rst16), .iSTART(start16), .oBUSY(busy16), .oDONE(done16),
        .oSTAGE(st16), .oRD_EN(rd16), .oRD_ADDR0(ra16[0]), .oRD_ADDR1(ra16[1]),
        .oRD_ADDR2(ra16[2]), .oRD_ADDR3(ra16[3]), .oTW_IDX(tw16), .oWR_EN(wr16),
        .oWR_ADDR0(wa16[0]), .oWR_ADDR1(wa16[1]), .oWR_ADDR2(wa16[2]), .oWR_ADDR3(wa16[3])
    );

    fft_stage_ctrl #(.N(64)) u64 (
        .iCLK(clk), .iRESET(rst_n), .iSTART(start64), .oBUSY(busy64), .oDONE(done64),
        .oSTAGE(st64), .oRD_EN(rd64), .oRD_ADDR0(ra64[0]), .oRD_ADDR1(ra64[1]),
        .oRD_ADDR2(ra64[2]), .oRD_ADDR3(ra64[3]), .oTW_IDX(tw64), .oWR_EN(wr64),
        .oWR_ADDR0(wa64[0]), .oWR_ADDR1(wa64[1]), .oWR_ADDR2(wa64[2]), .oWR_ADDR3(wa64[3])
    );

    fft_stage_ctrl #(.N(256)) u256 (
        .iCLK(clk), .iRESET(rst_n), .iSTART(start256), .oBUSY(busy256), .oDONE(done256),
        .oSTAGE(st256), .oRD_EN(rd256), .oRD_ADDR0(ra256[0]), .oRD_ADDR1(ra256[1]),
        .oRD_ADDR2(ra256[2]), .oRD_ADDR3(ra256[3]), .oTW_IDX(tw256), .oWR_EN(wr256),
        .oWR_ADDR0(wa256[0]), .oWR_ADDR1(wa256[1]), .oWR_ADDR2(wa256[2]), .oWR_ADDR3(wa256[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_rd16(input string tag, input int a0, input int a1, input int a2,
                            input int a3, input int tw);
        chk(tag, {ra16[0], ra16[1], ra16[2], ra16[3], tw16},
            {a0[3:0], a1[3:0], a2[3:0], a3[3:0], tw[3:0]});
    endtask

    task automatic chk_wr16(input string tag, input int a0, input int a1, input int a2,
                            input int a3);
        chk(tag, {wa16[0], wa16[1], wa16[2], wa16[3]}, {a0[3:0], a1[3:0], a2[3:0], a3[3:0]});
    endtask

    initial begin
        int i, n_done, first_done, d1, d2, r2, n_wr;
        logic e_rd, e_wr, e_busy, got_done;
        logic [63:0] e;

        rst16 = 1'b0; rst_n = 1'b0;
        start16 = 1'b0; start64 = 1'b0; start256 = 1'b0;
        repeat (3) tick();
        chk("rst_u16_outs", {busy16, done16, rd16, wr16, st16, tw16, ra16[0], wa16[3]}, 64'd0);
        chk("rst_u256_outs", {busy256, done256, rd256, wr256, st256, tw256, ra256[2], wa256[0]}, 64'd0);
        rst16 = 1'b1; rst_n = 1'b1;
        tick();

        // N=16 nominal run, start at cycle 0
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            e_rd   = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            e_wr   = (c >= 3 && c <= 6) || (c >= 9 && c <= 12);
            e_busy = (c >= 1 && c <= 12);
            chk("n16_rd_en", rd16, e_rd);
            chk("n16_wr_en", wr16, e_wr);
            chk("n16_busy", busy16, e_busy);
            chk("n16_done", done16, c == 13);
            if (c <= 12) chk("n16_stage", st16, (c >= 7) ? 1 : 0);
            if (c >= 1 && c <= 4) begin
                i = c - 1;
                chk_rd16("n16_s0_rd", i, i + 4, i + 8, i + 12, i);
            end
            if (c >= 7 && c <= 10) begin
                i = c - 7;
                chk_rd16("n16_s1_rd", 4 * i, 4 * i + 1, 4 * i + 2, 4 * i + 3, 0);
            end
            if (c >= 3 && c <= 6) begin
                i = c - 3;
                chk_wr16("n16_s0_wr", i, i + 4, i + 8, i + 12);
            end
            if (c >= 9 && c <= 12) begin
                i = c - 9;
                chk_wr16("n16_s1_wr", 4 * i, 4 * i + 1, 4 * i + 2, 4 * i + 3);
            end
            tick();
        end

        // iSTART re-pulsed during RUN and FLUSH is ignored
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        n_done = 0; first_done = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done16) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            start16 = (c == 2 || c == 5 || c == 11);
            tick();
        end
        start16 = 1'b0;
        chk("repulse_done_count", n_done, 1);
        chk("repulse_done_cycle", first_done, 13);

        // Synchronous reset mid-RUN
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        tick();
        rst16 = 1'b0;
        tick();
        rst16 = 1'b1;
        chk("midrst_outs", {busy16, done16, rd16, wr16, st16, tw16, ra16[0], ra16[1], wa16[0], wa16[1]}, 64'd0);
        for (int c = 4; c <= 8; c++) begin
            chk("midrst_quiet", {busy16, rd16, wr16, done16}, 4'd0);
            tick();
        end
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("fresh_rd_en", rd16, 1'b1);
        chk_rd16("fresh_rd0", 0, 4, 8, 12, 0);
        first_done = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done16 && first_done < 0) first_done = c;
            tick();
        end
        chk("fresh_done_cycle", first_done, 13);

        // N=64: stage 1, butterfly 5 lands at cycle 1 + 18 + 5
        start64 = 1'b1;
        tick();
        start64 = 1'b0;
        first_done = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c == 24) begin
                chk("n64_s1_b5_rd", {ra64[0], ra64[1], ra64[2], ra64[3], tw64},
                    {6'd17, 6'd21, 6'd25, 6'd29, 6'd4});
                chk("n64_s1_b5_ctl", {rd64, st64}, {1'b1, 4'd1});
            end
            if (done64 && first_done < 0) first_done = c;
            tick();
        end
        chk("n64_done_cycle", first_done, 55);

        // N=256 full run with write-back scoreboard
        start256 = 1'b1;
        tick();
        start256 = 1'b0;
        got_done = 1'b0; n_wr = 0;
        for (int c = 1; c <= 300 && !got_done; c++) begin
            if (rd256) exp_q.push_back({32'(c + 2), ra256[0], ra256[1], ra256[2], ra256[3]});
            if (wr256) begin
                n_wr++;
                chk("n256_wr_in_busy", busy256, 1'b1);
                if (exp_q.size() == 0) begin
                    chk("n256_wr_unexpected", wr256, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("n256_wr_align", {32'(c), wa256[0], wa256[1], wa256[2], wa256[3]}, e);
                end
            end
            if (c == 150) begin
                chk("n256_s2_b17_rd", {ra256[0], ra256[1], ra256[2], ra256[3], tw256},
                    {8'd65, 8'd69, 8'd73, 8'd77, 8'd16});
                chk("n256_s2_stage", st256, 4'd2);
            end
            if (done256) begin
                got_done = 1'b1;
                chk("n256_done_cycle", c, 265);
                chk("n256_no_wr_done", {wr256, rd256, busy256}, 3'd0);
            end
            tick();
        end
        chk("n256_done_seen", got_done, 1'b1);
        chk("n256_write_count", n_wr, 256);
        chk("n256_queue_empty", exp_q.size(), 0);

        // iSTART held high: back-to-back runs
        start16 = 1'b1;
        tick();
        d1 = -1; d2 = -1; r2 = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done16) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (rd16 && d1 >= 0 && r2 < 0) r2 = c;
            tick();
        end
        start16 = 1'b0;
        chk("held_done1", d1, 13);
        chk("held_rd2", r2, 15);
        chk("held_done2", d2, 27);
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
